// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, transmitter and their buffers.
package uart_pkg;
    localparam int UART_DATA_W = 8;
    typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x byte storage: synchronous write, asynchronous read, contents never reset.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [UART_DATA_W-1:0] wdata,
    input  logic [AW-1:0]          raddr,
    output logic [UART_DATA_W-1:0] rdata
);
    uart_byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: circular FIFO with a first-word-fall-through
// read port, registered occupancy flags and a sticky overrun indicator.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [UART_DATA_W-1:0]   wr_data,
    input  logic                     wr_en,
    output logic [UART_DATA_W-1:0]   rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    input  logic                     flush,
    input  logic                     clr_overrun,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          vld_q, vld_d, full_q, full_d, af_q, af_d, ovr_q, ovr_d;
    logic          pop, push, drop, wr_fire;
    uart_byte_t    ram_rd_data;

    uart_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (ram_rd_data)
    );

    always_comb begin
        pop      = vld_q && rd_ready;
        push     = wr_en && (!full_q || pop);
        drop     = wr_en && full_q && !pop && !flush;
        wr_fire  = push && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
        // Flags derive from the next count so they land on the same edge as it.
        vld_d  = (count_d != '0);
        full_d = (count_d == CW'(DEPTH));
        af_d   = (count_d >= CW'(AF_THRESH));
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop)             ovr_d = 1'b1;
        else if (clr_overrun) ovr_d = 1'b0;
        else                  ovr_d = ovr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= 1'b0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rd_data     = ram_rd_data;
    assign rd_valid    = vld_q;
    assign count       = count_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign overrun     = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_en = 1'b0, rd_ready = 1'b0, flush = 1'b0, clr_overrun = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, full, almost_full, overrun;
    logic [4:0] count;

    int total = 0;
    int bad   = 0;

    bit [7:0] mq[$];
    bit       m_ovr = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH), .AF_THRESH(AF)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .flush(flush), .clr_overrun(clr_overrun), .count(count),
        .full(full), .almost_full(almost_full), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic idle();
        wr_en = 0; rd_ready = 0; flush = 0; clr_overrun = 0;
    endtask

    // Advance one clock, updating the model from the current inputs; returns at edge+1.
    task automatic cycle();
        int  n;
        bit  pp, ps;
        n = mq.size();
        if (flush) begin
            mq.delete();
            if (clr_overrun) m_ovr = 0;
        end else begin
            pp = (n > 0) && rd_ready;
            ps = wr_en && (n < DEPTH || pp);
            if (pp) void'(mq.pop_front());
            if (ps) mq.push_back(wr_data);
            if (wr_en && !ps) m_ovr = 1;
            else if (clr_overrun) m_ovr = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic write_byte(input bit [7:0] b);
        idle(); wr_en = 1; wr_data = b; cycle(); idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1; repeat (2) @(posedge clk); #3 rst = 0;
        @(posedge clk); #1;
        total++; if (count !== 5'd0)      begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (rd_valid !== 1'b0)   begin bad++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
        total++; if (full !== 1'b0)       begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_af got=%b exp=0", almost_full); end
        total++; if (overrun !== 1'b0)    begin bad++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
    endtask

    task automatic test_basic();
        write_byte(8'hA5);
        write_byte(8'h3C);
        total++; if (count !== 5'd2)    begin bad++; $display("FAIL basic_count got=%0d exp=2", count); end
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", rd_valid); end
        total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL basic_head got=%h exp=a5", rd_data); end
        rd_ready = 1; cycle();
        total++; if (rd_data !== 8'h3C) begin bad++; $display("FAIL basic_second got=%h exp=3c", rd_data); end
        cycle(); idle();
        total++; if (rd_valid !== 1'b0 || count !== 5'd0) begin
            bad++; $display("FAIL basic_empty got=%b/%0d exp=0/0", rd_valid, count); end
    endtask

    task automatic test_fill_overrun();
        for (int i = 0; i < DEPTH; i++) begin
            write_byte(8'(i));
            total++; if (almost_full !== (i + 1 >= AF) || full !== (i + 1 == DEPTH)) begin
                bad++; $display("FAIL fill_flags n=%0d got af=%b full=%b", i + 1, almost_full, full); end
        end
        write_byte(8'hFF);
        total++; if (overrun !== 1'b1 || count !== 5'd16) begin
            bad++; $display("FAIL fill_drop got ovr=%b cnt=%0d exp 1/16", overrun, count); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                bad++; $display("FAIL fill_drain i=%0d got=%h v=%b exp=%h", i, rd_data, rd_valid, 8'(i)); end
            idle(); rd_ready = 1; cycle();
        end
        idle();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL fill_extra got v=%b data=%h exp v=0", rd_valid, rd_data); end
    endtask

    task automatic test_full_pushpop();
        idle(); clr_overrun = 1; cycle(); idle();
        for (int i = 0; i < DEPTH; i++) write_byte(8'h20 + 8'(i));
        wr_en = 1; wr_data = 8'h77; rd_ready = 1; cycle(); idle();
        total++; if (count !== 5'd16 || overrun !== 1'b0) begin
            bad++; $display("FAIL pushpop_full got cnt=%0d ovr=%b exp 16/0", count, overrun); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (rd_data !== mq[0]) begin
                bad++; $display("FAIL pushpop_drain i=%0d got=%h exp=%h", i, rd_data, mq[0]); end
            if (i == DEPTH - 1) begin
                total++; if (rd_data !== 8'h77) begin bad++; $display("FAIL pushpop_last got=%h exp=77", rd_data); end
            end
            rd_ready = 1; cycle(); idle();
        end
    endtask

    task automatic test_wrap();
        int maxc = 0;
        for (int i = 0; i < 40; i++) begin
            write_byte(8'($urandom));
            if (count > maxc) maxc = count;
            total++; if (rd_data !== mq[0]) begin
                bad++; $display("FAIL wrap_data i=%0d got=%h exp=%h", i, rd_data, mq[0]); end
            rd_ready = 1; cycle(); idle();
        end
        total++; if (maxc > 2) begin bad++; $display("FAIL wrap_count got max=%0d exp<=2", maxc); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) write_byte(8'($urandom_range(0, 80)));
        wr_en = 1; wr_data = 8'h55; flush = 1; cycle(); idle();
        total++; if (count !== 5'd0 || rd_valid !== 1'b0) begin
            bad++; $display("FAIL flush_empty got cnt=%0d v=%b exp 0/0", count, rd_valid); end
        write_byte(8'h11);
        total++; if (rd_data !== 8'h11) begin bad++; $display("FAIL flush_next got=%h exp=11", rd_data); end
        rd_ready = 1; cycle(); idle();
        for (int i = 0; i < DEPTH; i++) write_byte(8'(i));
        write_byte(8'hEE);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        wr_en = 1; wr_data = 8'hEF; clr_overrun = 1; cycle(); idle();
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_clr_vs_set got=%b exp=1", overrun); end
        clr_overrun = 1; cycle(); idle();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clr got=%b exp=0", overrun); end
        flush = 1; cycle(); idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wr_en = ($urandom_range(0, 99) < 60);
            wr_data = 8'($urandom);
            rd_ready = ($urandom_range(0, 99) < 45);
            flush = ($urandom_range(0, 99) < 3);
            clr_overrun = ($urandom_range(0, 99) < 8);
            cycle();
            total++; if (count !== 5'(mq.size()) || rd_valid !== (mq.size() > 0) || full !== (mq.size() == DEPTH)
                         || almost_full !== (mq.size() >= AF) || overrun !== m_ovr) begin
                bad++; $display("FAIL rand_state c=%0d got cnt=%0d v=%b f=%b af=%b o=%b exp cnt=%0d o=%b",
                                c, count, rd_valid, full, almost_full, overrun, mq.size(), m_ovr); end
            if (mq.size() > 0) begin
                total++; if (rd_data !== mq[0]) begin
                    bad++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, rd_data, mq[0]); end
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) write_byte(8'($urandom));
        wr_en = 1; clr_overrun = 0;
        #3 rst = 1; #1;
        total++; if (count !== 5'd0 || rd_valid !== 1'b0 || full !== 1'b0 || almost_full !== 1'b0 || overrun !== 1'b0) begin
            bad++; $display("FAIL async_rst got cnt=%0d v=%b f=%b af=%b o=%b exp all 0",
                            count, rd_valid, full, almost_full, overrun); end
        idle(); mq.delete(); m_ovr = 0;
        @(posedge clk); @(negedge clk); rst = 0;
        @(posedge clk); #1;
        write_byte(8'h9A);
        total++; if (count !== 5'd1 || rd_data !== 8'h9A || rd_valid !== 1'b1) begin
            bad++; $display("FAIL after_rst got cnt=%0d data=%h v=%b exp 1/9a/1", count, rd_data, rd_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overrun();
        test_full_pushpop();
        test_wrap();
        test_flush();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
